logic_unit_pipe: RTL and testbench
==================================

Name: logic_unit_pipe

Overview:
- Parametrised, pipelined successor to the fixed 16-bit bitwise gate blocks.
- Per-beat selectable bitwise op (AND/OR/XOR/NAND/NOR/XNOR/NOT/PASS) on two WIDTH-bit operands.
- Accumulate mode folds a multi-beat stream of operand a into one result. Used for mask reduction in the accelerator datapath.
- Valid/ready handshake on input and output; single registered output stage.

Parameters:
- WIDTH, 16, operand/result width in bits (>=1)
- CNT_W, 8, width of the beat counter reported with each result

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input beat offered
- in_ready  output  1  unit can accept a beat this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B (ignored in accumulate beats)
- op  input  3  0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT a, 7 PASS a
- acc  input  1  beat belongs to an accumulate burst
- last  input  1  final beat of accumulate burst (ignored when acc=0)
- out_valid  output  1  result held in output register
- out_ready  input  1  downstream accepts result
- out  output  WIDTH  result
- out_zero  output  1  registered (out == 0)
- out_beats  output  CNT_W  beats folded into this result (1 for non-acc)

Behaviour:
- Reset is asynchronous, active-low, and applies immediately at any point, including mid-burst.
  - Reset values: out_valid=0, out=0, out_zero=0, out_beats=0, internal acc_reg=0, in_burst=0, beat_cnt=0.
  - An open burst is discarded.
- in_ready = !out_valid || out_ready. This is combinational and identical for all beat types. A beat is accepted when in_valid && in_ready.
- Output register holds its value while out_valid && !out_ready. It is cleared to out_valid=0 when out_ready is high and no emitting beat is accepted that cycle.
- Non-acc beat (acc=0):
  - Result = op(a,b).
  - Registered next cycle with out_valid=1, out_beats=1.
  - Latency is 1 cycle. Burst state (acc_reg, in_burst, beat_cnt) is untouched, so non-acc beats may interleave with an open burst.
- Acc beat (acc=1):
  - Only ops 0..2 are legal. For ops 3..7 the beat is treated exactly as a non-acc beat.
  - If in_burst=0: acc_reg<=a, beat_cnt<=1, in_burst<=1.
  - If in_burst=1: acc_reg<=op(acc_reg,a), beat_cnt<=sat(beat_cnt+1). op is sampled per beat.
  - When last=1, the folded value (including this beat) is written to out with out_valid=1 and out_beats = the updated count. Then in_burst<=0 and beat_cnt<=0.
  - A single-beat burst (first beat with last=1) outputs a, out_beats=1.
  - Non-last acc beats produce no output.
- beat_cnt saturates at 2^CNT_W-1 and does not wrap.
- Throughput is 1 beat/cycle when out_ready is held high. Back-to-back emitting beats produce consecutive out_valid cycles.
- out_zero is updated in the same cycle as out and is valid only while out_valid=1.
- All ops are pure bitwise per lane. There is no carry and no width extension.

Test Plan:
- Reset/idle: assert rst_n=0 mid-cycle with out_valid=1 -> out_valid=0, out=0000h, out_beats=0 immediately. After release, in_ready=1.
- Non-acc ops, WIDTH=16, out_ready=1:
  - a=0110h, b=0047h, op=1 -> out=0157h one cycle later, out_beats=1, out_zero=0.
  - a=01A4h, b=0491h, op=0 -> out=0080h.
  - a=FFFFh, b=FFFFh, op=2 -> out=0000h, out_zero=1.
- Accumulate OR burst: beats a=0001h, 0010h, 8000h (op=1, acc=1, last on third) -> single result out=8011h, out_beats=3. No out_valid during the first two beats.
- Backpressure: hold out_ready=0 with out_valid=1 -> in_ready=0, out stable for 5 cycles. Release -> pending beat accepted the same cycle, next result the following cycle, no beat lost or duplicated.
- Interleave: open AND burst (a=FF0Fh), then non-acc a=1234h, b=0000h, op=7, then acc a=0F0Fh last=1 -> outputs 1234h (beats=1) then 0F0Fh (beats=2).
- Saturation: with CNT_W=2, a 5-beat acc burst -> out_beats=3.

Source files
------------

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: pipelined bitwise logic unit with per-beat op select and
// an accumulate mode that folds a multi-beat stream of operand a into one
// result. Valid/ready on both sides, single registered output stage.
module logic_unit_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc,
  input  logic             last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_zero,
  output logic [CNT_W-1:0] out_beats
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Pure per-lane bitwise op; no carry, no width extension.
  function automatic logic [WIDTH-1:0] bitop(input logic [2:0] sel,
                                             input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    case (sel)
      3'd0:    r = x & y;
      3'd1:    r = x | y;
      3'd2:    r = x ^ y;
      3'd3:    r = ~(x & y);
      3'd4:    r = ~(x | y);
      3'd5:    r = ~(x ^ y);
      3'd6:    r = ~x;
      default: r = x;
    endcase
    return r;
  endfunction

  logic [WIDTH-1:0] acc_reg;
  logic             in_burst;
  logic [CNT_W-1:0] beat_cnt;

  logic             accept;
  logic             acc_beat;
  logic             emit;
  logic [CNT_W-1:0] cnt_upd;
  logic [WIDTH-1:0] fold;
  logic [WIDTH-1:0] result;
  logic [CNT_W-1:0] result_beats;

  // Upstream may push whenever the output slot is empty or draining this cycle.
  assign in_ready = !out_valid || out_ready;

  // Beat classification, fold value and saturating beat count.
  always_comb begin
    accept       = in_valid && in_ready;
    acc_beat     = acc && (op <= 3'd2);
    emit         = accept && (!acc_beat || last);
    cnt_upd      = in_burst ? ((beat_cnt == CNT_MAX) ? beat_cnt : beat_cnt + CNT_ONE)
                            : CNT_ONE;
    fold         = in_burst ? bitop(op, acc_reg, a) : a;
    result       = acc_beat ? fold : bitop(op, a, b);
    result_beats = acc_beat ? cnt_upd : CNT_ONE;
  end

  // Output stage: load on an emitting beat, hold under backpressure, else drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= '0;
      out_zero  <= 1'b0;
      out_beats <= '0;
    end else if (emit) begin
      out_valid <= 1'b1;
      out       <= result;
      out_zero  <= (result == '0);
      out_beats <= result_beats;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Burst state advances only on legal accumulate beats; others leave it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg  <= '0;
      in_burst <= 1'b0;
      beat_cnt <= '0;
    end else if (accept && acc_beat) begin
      acc_reg <= fold;
      if (last) begin
        in_burst <= 1'b0;
        beat_cnt <= '0;
      end else begin
        in_burst <= 1'b1;
        beat_cnt <= cnt_upd;
      end
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe; a second instance with CNT_W=2 shares
// the stimulus to cover beat-count saturation.
module tb_logic_unit_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic [2:0]  op;
  logic        acc;
  logic        last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic        out_zero;
  logic [7:0]  out_beats;

  logic        s_in_ready;
  logic        s_out_valid;
  logic [15:0] s_out;
  logic        s_out_zero;
  logic [1:0]  s_out_beats;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(16), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .acc(acc), .last(last),
    .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .out_zero(out_zero), .out_beats(out_beats)
  );

  logic_unit_pipe #(.WIDTH(16), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .a(a), .b(b), .op(op), .acc(acc), .last(last),
    .out_valid(s_out_valid), .out_ready(out_ready), .out(s_out),
    .out_zero(s_out_zero), .out_beats(s_out_beats)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [15:0] ta, input logic [15:0] tb_v, input logic [2:0] top,
                      input logic tacc, input logic tlast);
    in_valid = 1'b1;
    a        = ta;
    b        = tb_v;
    op       = top;
    acc      = tacc;
    last     = tlast;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    acc      = 1'b0;
    last     = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [15:0] eo, input logic [7:0] eb,
                         input logic ez);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_out"},   32'(out), 32'(eo));
    chk({tag, "_beats"}, 32'(out_beats), 32'(eb));
    chk({tag, "_zero"},  32'(out_zero), 32'(ez));
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b1;
    a = '0; b = '0; op = '0;
    idle();
    tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_out",   32'(out), 32'd0);
    chk("rst_beats", 32'(out_beats), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // Non-accumulate ops, one-cycle latency, back-to-back.
    beat(16'h0110, 16'h0047, 3'd1, 1'b0, 1'b0);
    tick();
    chk_out("or", 16'h0157, 8'd1, 1'b0);
    beat(16'h01A4, 16'h0491, 3'd0, 1'b0, 1'b0);
    tick();
    chk_out("and", 16'h0080, 8'd1, 1'b0);
    beat(16'hFFFF, 16'hFFFF, 3'd2, 1'b0, 1'b0);
    tick();
    chk_out("xor", 16'h0000, 8'd1, 1'b1);
    beat(16'h00FF, 16'h0000, 3'd6, 1'b0, 1'b0);
    tick();
    chk_out("not", 16'hFF00, 8'd1, 1'b0);
    idle();
    tick();
    chk("drain_valid", 32'(out_valid), 32'd0);

    // Accumulate OR burst of three beats.
    beat(16'h0001, 16'h0000, 3'd1, 1'b1, 1'b0);
    tick();
    chk("accor_b1_valid", 32'(out_valid), 32'd0);
    beat(16'h0010, 16'h0000, 3'd1, 1'b1, 1'b0);
    tick();
    chk("accor_b2_valid", 32'(out_valid), 32'd0);
    beat(16'h8000, 16'h0000, 3'd1, 1'b1, 1'b1);
    tick();
    chk_out("accor", 16'h8011, 8'd3, 1'b0);
    idle();
    tick();
    chk("accor_drain", 32'(out_valid), 32'd0);

    // Backpressure: result held, in_ready low, pending beat taken on release.
    out_ready = 1'b0;
    beat(16'h00F0, 16'h0F00, 3'd2, 1'b0, 1'b0);
    tick();
    chk_out("bp_first", 16'h0FF0, 8'd1, 1'b0);
    beat(16'hAAAA, 16'h5555, 3'd1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_out", 32'(out), 32'h0FF0);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    tick();
    chk_out("bp_second", 16'hFFFF, 8'd1, 1'b0);
    idle();
    tick();
    chk("bp_no_dup", 32'(out_valid), 32'd0);

    // Non-acc beat interleaved with an open AND burst.
    beat(16'hFF0F, 16'h0000, 3'd0, 1'b1, 1'b0);
    tick();
    chk("il_open_valid", 32'(out_valid), 32'd0);
    beat(16'h1234, 16'h0000, 3'd7, 1'b0, 1'b0);
    tick();
    chk_out("il_pass", 16'h1234, 8'd1, 1'b0);
    beat(16'h0F0F, 16'h0000, 3'd0, 1'b1, 1'b1);
    tick();
    chk_out("il_close", 16'h0F0F, 8'd2, 1'b0);

    // acc=1 with op 3 (NAND) behaves as a plain beat.
    beat(16'hF0F0, 16'hFF00, 3'd3, 1'b1, 1'b0);
    tick();
    chk_out("acc_nand", 16'h0FFF, 8'd1, 1'b0);
    // Single-beat burst yields a itself.
    beat(16'h0000, 16'hFFFF, 3'd2, 1'b1, 1'b1);
    tick();
    chk_out("single", 16'h0000, 8'd1, 1'b1);

    // Five-beat XOR burst: 8-bit counter reports 5, 2-bit counter saturates at 3.
    for (int i = 0; i < 5; i++) begin
      beat(16'(16'h0001 << i), 16'h0000, 3'd2, 1'b1, (i == 4) ? 1'b1 : 1'b0);
      tick();
    end
    chk_out("sat_main", 16'h001F, 8'd5, 1'b0);
    chk("sat_valid", 32'(s_out_valid), 32'd1);
    chk("sat_out",   32'(s_out), 32'h001F);
    chk("sat_beats", 32'(s_out_beats), 32'd3);

    // Asynchronous reset mid-cycle with a result held and a burst open.
    beat(16'h1111, 16'h0000, 3'd1, 1'b1, 1'b0);
    tick();
    beat(16'h0000, 16'h0000, 3'd4, 1'b0, 1'b0);
    tick();
    chk_out("pre_rst", 16'hFFFF, 8'd1, 1'b0);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_out",   32'(out), 32'd0);
    chk("arst_beats", 32'(out_beats), 32'd0);
    chk("arst_zero",  32'(out_zero), 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 32'(in_ready), 32'd1);
    beat(16'h0022, 16'h0000, 3'd1, 1'b1, 1'b1);
    tick();
    chk_out("burst_discard", 16'h0022, 8'd1, 1'b0);
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
